id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage that sits directly downstream of the register file.
- Captures the two register-file read operands together with the decoded instruction fields, and presents them to the execute stage.
- Owns load-use hazard detection. On a hazard it inserts one bubble and back-pressures decode.
- Supports a downstream stall (hold) and a branch/exception flush.

Parameters:
XLEN, 32, data and PC width
CTRL_W, 12, width of the decoded control bundle
LOAD_BIT, 0, bit index in ctrl that marks a memory-read (load) instruction

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  decode presents a valid instruction
id_ready  output  1  stage accepts the decode instruction this cycle
id_pc  input  XLEN  instruction PC
id_rs1  input  5  source register 1 index (drives register file ReadReg1)
id_rs2  input  5  source register 2 index (drives register file ReadReg2)
id_rs1_used  input  1  instruction actually reads rs1
id_rs2_used  input  1  instruction actually reads rs2
id_rd  input  5  destination register index
id_imm  input  XLEN  sign-extended immediate
id_ctrl  input  CTRL_W  decoded control bundle
rf_rdata1  input  XLEN  register file ReadData1
rf_rdata2  input  XLEN  register file ReadData2
wb_we  input  1  write-back stage writes the register file this cycle
wb_rd  input  5  write-back destination
wb_wdata  input  XLEN  write-back data
ex_ready  input  1  execute stage can accept a new entry
flush  input  1  kill the ID/EX contents and the incoming instruction
ex_valid  output  1  entry valid
ex_pc, ex_imm  output  XLEN  registered copies
ex_rs1, ex_rs2, ex_rd  output  5  registered indices
ex_ctrl  output  CTRL_W  registered control (all-zero when bubble)
ex_rs1_data, ex_rs2_data  output  XLEN  registered operands
load_use_stall  output  1  combinational hazard indication

Behaviour:
- Reset: rst sampled on the clk edge. Every ex_* output becomes 0 and ex_valid becomes 0. Reset overrides flush, hold and capture.
- Hazard definition. hazard = id_valid & ex_valid & ex_ctrl[LOAD_BIT] & (ex_rd != 0), AND at least one of:
  - id_rs1_used & id_rs1 == ex_rd
  - id_rs2_used & id_rs2 == ex_rd
- load_use_stall = hazard.
- id_ready = ex_ready & ~hazard & ~flush.
- Priority per edge: rst > flush > hold > bubble > capture.
  - flush=1: ex_valid<=0 and ex_ctrl<=0 (other fields hold). Incoming instruction dropped. Applies even when ex_ready=0.
  - ex_ready=0: all registers hold. No capture, no bubble.
  - ex_ready=1 & hazard: bubble. ex_valid<=0, ex_ctrl<=0, ex_rd<=0.
    - The load then leaves the stage, so the hazard lasts exactly one cycle.
    - The stalled instruction is captured on the following edge, provided ex_ready=1.
  - ex_ready=1 & ~hazard:
    - ex_valid<=id_valid.
    - If id_valid, all fields are captured.
    - If ~id_valid, ex_ctrl<=0 and ex_rd<=0.
- Latency: one cycle from decode acceptance to ex_valid.
- Operand capture: ex_rsN_data <= rf_rdataN, modified by the optional feature below. Register x0 data is always captured as 0, regardless of rf_rdata.
- ex_ctrl is all-zero whenever ex_valid=0, so execute and memory never act on a bubble.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: the register file writes on the clock edge and reads combinationally, so it does not forward same-cycle writes. This stage therefore forwards them:
  - On capture, if wb_we & wb_rd != 0 & wb_rd == id_rsN, capture wb_wdata instead of rf_rdataN.
  - While holding (ex_ready=0) or after a bubble, if ex_valid & wb_we & wb_rd != 0 & wb_rd == ex_rsN, refresh ex_rsN_data <= wb_wdata. Held operands never go stale.
- Undefined: operands come directly from rf_rdataN with no refresh. The integration must guarantee write-back does not target a pending source register.

Test Plan:
- Reset: drive rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, ex_ctrl=0, all data 0; id_ready reflects ex_ready.
- Capture: id_valid=1, pc=0x100, rs1=5, rs2=6, rf_rdata1=0x11, rf_rdata2=0x22, ex_ready=1 -> next cycle:
  - ex_valid=1, ex_pc=0x100, ex_rs1_data=0x11, ex_rs2_data=0x22.
  - Same test with rs1=0 and rf_rdata1=0xDEAD -> ex_rs1_data=0.
- Load-use: EX holds a load with rd=7; ID instruction has rs2=7 and rs2_used=1 ->
  - load_use_stall=1 and id_ready=0 for exactly 1 cycle; bubble with ex_ctrl=0.
  - Instruction captured on the next edge.
  - With rs2_used=0 -> no stall.
- Hold and flush:
  - ex_ready=0 for 3 cycles -> ex_* stable.
  - Assert flush while ex_ready=0 -> ex_valid=0 next cycle; the ID instruction is not captured.
- Bypass (WB_BYPASS_EN):
  - Capture rs1=9 while wb_we=1, wb_rd=9, wb_wdata=0xABCD, rf_rdata1=0x1 -> ex_rs1_data=0xABCD.
  - During hold, wb write to ex_rs2 -> ex_rs2_data updates.
  - wb_rd=0 -> no bypass.
- Simultaneous: flush=1 and hazard=1 with ex_ready=1 -> flush wins: ex_valid=0, id_ready=0, nothing captured next edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundle of decode, register-file, write-back and execute-side signals around the ID/EX stage.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12
);
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   rf_rdata1;
    logic [XLEN-1:0]   rf_rdata2;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_wdata;
    logic              ex_ready;
    logic              flush;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic              load_use_stall;

    // Handshakes: decode->stage transfers on an edge where id_valid && id_ready;
    // stage->execute advances on an edge where ex_ready is high (ex_valid marks a real entry).
    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_imm, id_ctrl, rf_rdata1, rf_rdata2, wb_we, wb_rd, wb_wdata,
               ex_ready, flush,
        input  id_ready, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
               ex_rs1_data, ex_rs2_data, load_use_stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_imm, id_ctrl, rf_rdata1, rf_rdata2, wb_we, wb_rd, wb_wdata,
               ex_ready, flush,
        output id_ready, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
               ex_rs1_data, ex_rs2_data, load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data into captured/held operands.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int CTRL_W   = 12,
    parameter int LOAD_BIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [XLEN-1:0]   r_d1;
    logic [XLEN-1:0]   r_d2;

    logic              w_dep1;
    logic              w_dep2;
    logic              w_hazard;
    logic [XLEN-1:0]   w_cap1;
    logic [XLEN-1:0]   w_cap2;
    logic              w_ref1;
    logic              w_ref2;

    assign w_dep1   = bus.id_rs1_used && (bus.id_rs1 == r_rd);
    assign w_dep2   = bus.id_rs2_used && (bus.id_rs2 == r_rd);
    assign w_hazard = bus.id_valid && r_valid && r_ctrl[LOAD_BIT] && (r_rd != 5'd0)
                      && (w_dep1 || w_dep2);

`ifdef WB_BYPASS_EN
    // The register file does not forward its own same-edge write, so do it here.
    assign w_cap1 = (bus.id_rs1 == 5'd0) ? {XLEN{1'b0}} :
                    (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs1)) ?
                    bus.wb_wdata : bus.rf_rdata1;
    assign w_cap2 = (bus.id_rs2 == 5'd0) ? {XLEN{1'b0}} :
                    (bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs2)) ?
                    bus.wb_wdata : bus.rf_rdata2;
    assign w_ref1 = r_valid && bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == r_rs1);
    assign w_ref2 = r_valid && bus.wb_we && (bus.wb_rd != 5'd0) && (bus.wb_rd == r_rs2);
`else
    assign w_cap1 = (bus.id_rs1 == 5'd0) ? {XLEN{1'b0}} : bus.rf_rdata1;
    assign w_cap2 = (bus.id_rs2 == 5'd0) ? {XLEN{1'b0}} : bus.rf_rdata2;
    assign w_ref1 = 1'b0;
    assign w_ref2 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_ctrl  <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (!bus.ex_ready) begin
            if (w_ref1) r_d1 <= bus.wb_wdata;
            if (w_ref2) r_d2 <= bus.wb_wdata;
        end else if (w_hazard) begin
            // The load moves on; the stalled instruction is taken next edge.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            if (w_ref1) r_d1 <= bus.wb_wdata;
            if (w_ref2) r_d2 <= bus.wb_wdata;
        end else if (bus.id_valid) begin
            r_valid <= 1'b1;
            r_pc    <= bus.id_pc;
            r_imm   <= bus.id_imm;
            r_rs1   <= bus.id_rs1;
            r_rs2   <= bus.id_rs2;
            r_rd    <= bus.id_rd;
            r_ctrl  <= bus.id_ctrl;
            r_d1    <= w_cap1;
            r_d2    <= w_cap2;
        end else begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= '0;
        end
    end

    assign bus.id_ready       = bus.ex_ready && !w_hazard && !bus.flush;
    assign bus.load_use_stall = w_hazard;
    assign bus.ex_valid       = r_valid;
    assign bus.ex_pc          = r_pc;
    assign bus.ex_imm         = r_imm;
    assign bus.ex_rs1         = r_rs1;
    assign bus.ex_rs2         = r_rs2;
    assign bus.ex_rd          = r_rd;
    assign bus.ex_ctrl        = r_ctrl;
    assign bus.ex_rs1_data    = r_d1;
    assign bus.ex_rs2_data    = r_d2;

endmodule
